// File: rtl/mux_arbiter.sv
// Three-source packet mux arbiter: round-robin grant on packet heads, lock the
// winner until its tail transfers, report last packet length and protocol errors.
module mux_arbiter #(
    parameter int               TYPEW         = 3,
    parameter logic [TYPEW-1:0] TYPE_NONE     = 3'd0,
    parameter logic [TYPEW-1:0] TYPE_HEAD     = 3'd1,
    parameter logic [TYPEW-1:0] TYPE_DATA     = 3'd2,
    parameter logic [TYPEW-1:0] TYPE_TAIL     = 3'd3,
    parameter logic [TYPEW-1:0] TYPE_HEADTAIL = 3'd4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ivalid_2,
    input  logic [TYPEW-1:0] itype_0,
    input  logic [TYPEW-1:0] itype_1,
    input  logic [TYPEW-1:0] itype_2,
    input  logic             oready,
    output logic [2:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             iready_2,
    output logic             busy,
    output logic [7:0]       pkt_len,
    output logic             err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic [1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_pkt_len, w_pkt_len_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_err, w_err_nxt;

    logic [2:0]       w_valid;
    logic [2:0]       w_req;
    logic             w_grant_vld;
    logic [1:0]       w_winner;
    logic             w_own_valid;
    logic [TYPEW-1:0] w_own_type;
    logic             w_busy;
    logic             w_xfer;
    logic             w_is_end;
    logic [7:0]       w_cnt_inc;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic is_head(input logic [TYPEW-1:0] t);
        return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
    endfunction

    assign w_valid = {ivalid_2, ivalid_1, ivalid_0};
    assign w_req   = {ivalid_2 & is_head(itype_2),
                      ivalid_1 & is_head(itype_1),
                      ivalid_0 & is_head(itype_0)};

    // Scan from the far end so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_winner    = r_rr_ptr;
        for (int k = 2; k >= 0; k--) begin
            if (w_req[mod3_add(r_rr_ptr, 2'(k))]) begin
                w_grant_vld = 1'b1;
                w_winner    = mod3_add(r_rr_ptr, 2'(k));
            end
        end
    end

    always_comb begin
        case (r_owner)
            2'd1:    begin w_own_valid = ivalid_1; w_own_type = itype_1; end
            2'd2:    begin w_own_valid = ivalid_2; w_own_type = itype_2; end
            default: begin w_own_valid = ivalid_0; w_own_type = itype_0; end
        endcase
    end

    assign w_busy    = (r_state == S_BUSY);
    assign w_xfer    = w_busy && w_own_valid && oready;
    assign w_is_end  = (w_own_type == TYPE_TAIL) || (w_own_type == TYPE_HEADTAIL);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cnt_nxt     = r_cnt;
        w_pkt_len_nxt = r_pkt_len;
        w_sel_nxt     = r_sel;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = S_BUSY;
                    w_owner_nxt = w_winner;
                    w_sel_nxt   = 3'b001 << w_winner;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_BUSY: begin
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                    // The head is always the first flit, so a head or idle code later is malformed.
                    if ((r_cnt != 8'd0) &&
                        ((w_own_type == TYPE_HEAD) || (w_own_type == TYPE_NONE))) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_is_end) begin
                        w_state_nxt   = S_IDLE;
                        w_sel_nxt     = 3'b000;
                        w_rr_ptr_nxt  = mod3_add(r_owner, 2'd1);
                        w_pkt_len_nxt = w_cnt_inc;
                        w_cnt_nxt     = 8'd0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_rr_ptr  <= 2'd0;
            r_cnt     <= 8'd0;
            r_pkt_len <= 8'd0;
            r_sel     <= 3'b000;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pkt_len <= w_pkt_len_nxt;
            r_sel     <= w_sel_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign sel      = r_sel;
    assign busy     = w_busy;
    assign pkt_len  = r_pkt_len;
    assign err      = r_err;
    assign iready_0 = w_busy && (r_owner == 2'd0) && oready;
    assign iready_1 = w_busy && (r_owner == 2'd1) && oready;
    assign iready_2 = w_busy && (r_owner == 2'd2) && oready;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed vector table, hand-written packet scenarios and
// randomized traffic checked against a packet-level reference model.
module tb_mux_arbiter;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_HEAD = 3'd1;
    localparam logic [2:0] T_DATA = 3'd2;
    localparam logic [2:0] T_TAIL = 3'd3;
    localparam logic [2:0] T_HT   = 3'd4;

    logic       clk    = 1'b0;
    logic       rst_   = 1'b0;
    logic       oready = 1'b0;
    logic [2:0] v      = 3'b000;
    logic [2:0] ty [3];
    logic [2:0] sel;
    logic       iready_0, iready_1, iready_2, busy, err;
    logic [7:0] pkt_len;

    mux_arbiter dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid_0 (v[0]),
        .ivalid_1 (v[1]),
        .ivalid_2 (v[2]),
        .itype_0  (ty[0]),
        .itype_1  (ty[1]),
        .itype_2  (ty[2]),
        .oready   (oready),
        .sel      (sel),
        .iready_0 (iready_0),
        .iready_1 (iready_1),
        .iready_2 (iready_2),
        .busy     (busy),
        .pkt_len  (pkt_len),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference model: ownership, round-robin start, flit count, error flag.
    bit m_busy, m_err;
    int m_owner, m_rr, m_cnt, m_len;

    typedef logic [2:0] flit_q_t [$];
    flit_q_t  q [3];
    bit [2:0] gate = 3'b111;

    logic [2:0] s_sel, s_rdy;
    logic       s_busy, s_err;
    logic [7:0] s_len;

    function automatic logic [15:0] dut_out();
        return {sel, iready_2, iready_1, iready_0, busy, pkt_len, err};
    endfunction

    function automatic logic [15:0] model_out();
        logic [2:0] esel, erdy;
        esel = m_busy ? 3'(1 << m_owner) : 3'b000;
        erdy = (m_busy && oready) ? esel : 3'b000;
        return {esel, erdy, m_busy, 8'(m_len), m_err};
    endfunction

    task automatic drive();
        for (int n = 0; n < 3; n++) begin
            v[n]  = gate[n] && (q[n].size() != 0);
            ty[n] = (q[n].size() != 0) ? q[n][0] : T_NONE;
        end
    endtask

    task automatic model_step();
        bit         found;
        int         p;
        logic [2:0] t;
        found = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
                p = (m_rr + k) % 3;
                if (!found && v[p] && (ty[p] == T_HEAD || ty[p] == T_HT)) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = p;
                    m_cnt   = 0;
                end
            end
        end else if (v[m_owner] && oready) begin
            t = ty[m_owner];
            void'(q[m_owner].pop_front());
            if (m_cnt > 0 && (t == T_HEAD || t == T_NONE)) m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (t == T_TAIL || t == T_HT) begin
                m_len  = m_cnt;
                m_cnt  = 0;
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % 3;
            end
        end
    endtask

    // One cycle: compare mid-cycle, advance model on the edge, re-drive sources.
    task automatic tick(input string name);
        #2;
        {s_sel, s_rdy, s_busy, s_len, s_err} = dut_out();
        check(name, dut_out(), model_out());
        @(posedge clk);
        model_step();
        #1 drive();
    endtask

    task automatic do_reset();
        #1 rst_ = 1'b0;
        #1 check("reset_outputs", dut_out(), 16'h0000);
        m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_len = 0; m_err = 0;
        for (int n = 0; n < 3; n++) q[n].delete();
        gate   = 3'b111;
        oready = 1'b0;
        drive();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [2:0] s);
        int r;
        r = -1;
        for (int i = 0; i < 3; i++) if (s == 3'(1 << i)) r = i;
        return r;
    endfunction

    typedef struct {
        logic [2:0] v;
        logic [2:0] t0, t1, t2;
        logic       ordy;
        logic [2:0] e_sel;
        logic [2:0] e_rdy;
        logic       e_busy;
        logic [7:0] e_len;
        logic       e_err;
    } vec_t;

    vec_t vt [10];
    int   n_rdy;
    int   order [$];
    int   starts [$];
    int   plen;

    initial begin
        for (int n = 0; n < 3; n++) ty[n] = T_NONE;

        // Directed table: stray data ignored, headtail on port 2, stalled head on port 0.
        vt[0] = '{3'b000, T_NONE, T_NONE, T_NONE, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0, 1'b0};
        vt[1] = '{3'b011, T_DATA, T_TAIL, T_NONE, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0, 1'b0};
        vt[2] = '{3'b100, T_NONE, T_NONE, T_HT,   1'b1, 3'b000, 3'b000, 1'b0, 8'd0, 1'b0};
        vt[3] = '{3'b100, T_NONE, T_NONE, T_HT,   1'b1, 3'b100, 3'b100, 1'b1, 8'd0, 1'b0};
        vt[4] = '{3'b000, T_NONE, T_NONE, T_NONE, 1'b1, 3'b000, 3'b000, 1'b0, 8'd1, 1'b0};
        vt[5] = '{3'b001, T_HEAD, T_NONE, T_NONE, 1'b0, 3'b000, 3'b000, 1'b0, 8'd1, 1'b0};
        vt[6] = '{3'b001, T_HEAD, T_NONE, T_NONE, 1'b0, 3'b001, 3'b000, 1'b1, 8'd1, 1'b0};
        vt[7] = '{3'b001, T_HEAD, T_NONE, T_NONE, 1'b1, 3'b001, 3'b001, 1'b1, 8'd1, 1'b0};
        vt[8] = '{3'b001, T_TAIL, T_NONE, T_NONE, 1'b1, 3'b001, 3'b001, 1'b1, 8'd1, 1'b0};
        vt[9] = '{3'b000, T_NONE, T_NONE, T_NONE, 1'b1, 3'b000, 3'b000, 1'b0, 8'd2, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            v      = vt[i].v;
            ty[0]  = vt[i].t0;
            ty[1]  = vt[i].t1;
            ty[2]  = vt[i].t2;
            oready = vt[i].ordy;
            #2 check($sformatf("table_row%0d", i), dut_out(),
                     {vt[i].e_sel, vt[i].e_rdy, vt[i].e_busy, vt[i].e_len, vt[i].e_err});
            @(posedge clk);
            #1;
        end

        // 22-flit packet on source 1.
        do_reset();
        q[1].push_back(T_HEAD);
        repeat (20) q[1].push_back(T_DATA);
        q[1].push_back(T_TAIL);
        oready = 1'b1;
        drive();
        tick("s1_head_visible");
        n_rdy = 0;
        for (int i = 0; i < 30; i++) begin
            tick("s1_cycle");
            if (i == 0) check("s1_grant_latency", 32'(s_sel), 32'h2);
            if (s_rdy[1]) n_rdy++;
        end
        check("s1_iready_cycles", n_rdy, 22);
        check("s1_sel_after", 32'(s_sel), 32'h0);
        check("s1_pkt_len", 32'(s_len), 32'd22);

        // All three sources hold heads from reset: grants 0,1,2 with one idle gap.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            q[n].push_back(T_HEAD);
            q[n].push_back(T_DATA);
            q[n].push_back(T_TAIL);
        end
        oready = 1'b1;
        drive();
        order.delete();
        starts.delete();
        for (int i = 0; i < 16; i++) begin
            tick("rr_cycle");
            if (s_sel != 3'b000 && (i == 0 || starts.size() == 0 || s_sel != 3'(1 << order[$]))) begin
                order.push_back(onehot_idx(s_sel));
                starts.push_back(i);
            end
        end
        check("rr_grant_count", order.size(), 3);
        for (int k = 0; k < 3 && k < order.size(); k++) begin
            check($sformatf("rr_order%0d", k), order[k], k);
            check($sformatf("rr_start%0d", k), starts[k], 1 + 4 * k);
        end

        // Output stall mid-packet.
        do_reset();
        q[0].push_back(T_HEAD);
        repeat (3) q[0].push_back(T_DATA);
        q[0].push_back(T_TAIL);
        oready = 1'b1;
        drive();
        repeat (3) tick("stall_pre");
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("stall_cycle");
            check("stall_sel", 32'(s_sel), 32'h1);
            check("stall_rdy", 32'(s_rdy), 32'h0);
            check("stall_len", 32'(s_len), 32'h0);
        end
        oready = 1'b1;
        repeat (6) tick("stall_post");
        check("stall_pkt_len", 32'(s_len), 32'd5);

        // Head injected mid-packet: sticky error, packet still completes.
        do_reset();
        q[1] = '{T_HEAD, T_DATA, T_HEAD, T_DATA, T_TAIL};
        oready = 1'b1;
        drive();
        repeat (10) tick("err_pkt");
        check("err_set", 32'(s_err), 32'h1);
        check("err_pkt_len", 32'(s_len), 32'd5);
        repeat (4) tick("err_idle");
        check("err_sticky", 32'(s_err), 32'h1);

        // Saturating length counter.
        do_reset();
        q[0].push_back(T_HEAD);
        repeat (300) q[0].push_back(T_DATA);
        q[0].push_back(T_TAIL);
        oready = 1'b1;
        drive();
        repeat (306) tick("sat_cycle");
        check("sat_pkt_len", 32'(s_len), 32'd255);

        // Reset mid-packet, then lowest-index requester wins.
        do_reset();
        q[2].push_back(T_HEAD);
        repeat (10) q[2].push_back(T_DATA);
        q[2].push_back(T_TAIL);
        oready = 1'b1;
        drive();
        repeat (4) tick("mid_rst_pkt");
        check("mid_rst_busy", 32'(s_busy), 32'h1);
        do_reset();
        q[1].push_back(T_HT);
        q[2].push_back(T_HT);
        oready = 1'b1;
        drive();
        repeat (2) tick("post_rst");
        check("post_rst_grant", 32'(s_sel), 32'h2);
        repeat (4) tick("post_rst_drain");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick("rand_cycle");
            for (int n = 0; n < 3; n++) begin
                if (q[n].size() == 0 && $urandom_range(0, 5) == 0) begin
                    plen = $urandom_range(1, 6);
                    if (plen == 1) q[n].push_back(T_HT);
                    else begin
                        q[n].push_back(T_HEAD);
                        for (int j = 1; j < plen - 1; j++)
                            q[n].push_back(($urandom_range(0, 15) == 0) ?
                                           (($urandom_range(0, 1) == 1) ? T_HEAD : T_NONE) : T_DATA);
                        q[n].push_back(T_TAIL);
                    end
                end
                gate[n] = ($urandom_range(0, 3) != 0);
            end
            oready = ($urandom_range(0, 3) != 0);
            drive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL take parameter TYPEW, default 3, as the flit type field width.
REQ-002 The block SHALL take parameter TYPE_NONE, default 3'd0, as the idle or empty flit code.
REQ-003 The block SHALL take parameter TYPE_HEAD, default 3'd1, as the packet head code.
REQ-004 The block SHALL take parameter TYPE_DATA, default 3'd2, as the payload flit code.
REQ-005 The block SHALL take parameter TYPE_TAIL, default 3'd3, as the packet tail code.
REQ-006 The block SHALL take parameter TYPE_HEADTAIL, default 3'd4, as the single-flit packet code.
REQ-007 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port `rst_`: input, 1 bit, reset, asynchronous and active-low.
REQ-009 The block SHALL have ports `ivalid_0`, `ivalid_1`, `ivalid_2`: input, 1 bit each, source n presents a flit.
REQ-010 The block SHALL have ports `itype_0`, `itype_1`, `itype_2`: input, TYPEW bits each, the type field of source n's flit.
REQ-011 The block SHALL have port `oready`: input, 1 bit, the mux output consumer accepts a flit this cycle.
REQ-012 The block SHALL have port `sel`: output, 3 bits, one-hot mux select (bit n selects idata_n), registered.
REQ-013 The block SHALL have ports `iready_0`, `iready_1`, `iready_2`: output, 1 bit each, source n's flit is taken this cycle.
REQ-014 The block SHALL have port `busy`: output, 1 bit, a packet is locked through the mux.
REQ-015 The block SHALL have port `pkt_len`: output, 8 bits, flit count of the last completed packet, head included, saturating at 255.
REQ-016 The block SHALL have port `err`: output, 1 bit, sticky protocol-error flag.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and BUSY, an owner register (0..2), a round-robin pointer rr_ptr (0..2) and an 8-bit flit counter.
REQ-018 req_n SHALL be defined as ivalid_n AND (itype_n == TYPE_HEAD OR itype_n == TYPE_HEADTAIL).
REQ-019 In IDLE with any req_n high, the winner SHALL be the first requester scanning rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
REQ-020 On the cycle after REQ-019, the FSM SHALL enter BUSY, with owner = winner, sel = one-hot(winner) and busy = 1.
REQ-021 Grant latency SHALL be exactly 1 cycle from the head becoming visible to sel asserting.
REQ-022 In IDLE, sel SHALL be 3'b000 and all iready_n SHALL be 0.
REQ-023 In IDLE, any source presenting TYPE_DATA or TYPE_TAIL with ivalid high SHALL be ignored.
REQ-024 iready_n SHALL be combinational and equal to (state == BUSY) AND (owner == n) AND oready.
REQ-025 A flit transfer SHALL be defined as ivalid_owner AND iready_owner; the source holds its flit until that cycle.
REQ-026 In BUSY, the counter SHALL increment (saturating at 255) on every transfer; the head transfer counts as 1.
REQ-027 In BUSY, a transfer of TYPE_TAIL or TYPE_HEADTAIL SHALL cause, on the next edge: state = IDLE, sel = 000, busy = 0, rr_ptr = (owner+1) mod 3, pkt_len = final count, counter cleared.
REQ-028 Re-arbitration SHALL have one IDLE bubble cycle between packets, so back-to-back packets cost 1 extra cycle.
REQ-029 In BUSY, ivalid_owner low or oready low SHALL stall the packet: no transfer, state held, sel held, with no timeout.
REQ-030 In BUSY, requests from non-owners SHALL be ignored.
REQ-031 A non-owner request pending at end of packet SHALL win over the finishing owner via the rr_ptr advance.
REQ-032 In BUSY, a transfer of TYPE_HEAD or TYPE_NONE after the first flit SHALL set err = 1, and the packet SHALL continue.
REQ-033 err SHALL clear only on reset.
REQ-034 A TYPE_HEADTAIL winner SHALL give busy for exactly 1 transfer and pkt_len = 1.

Reset
REQ-035 While rst_ is low, asynchronously: state = IDLE, owner = 0, rr_ptr = 0, counter = 0, sel = 000, iready_n = 0, busy = 0, pkt_len = 0, err = 0.
REQ-036 Reset asserted mid-packet SHALL abandon the packet immediately with no pkt_len update.
REQ-037 Reset release SHALL be synchronous to the next clk edge.
REQ-038 The first arbitration after reset SHALL favour port 0.

Verification
REQ-039 The bench SHALL cover: single source 1, a 22-flit packet (head, 20 data, tail) with oready = 1 -> sel = 010 one cycle after the head, iready_1 high for 22 cycles, then sel = 000 and pkt_len = 22.
REQ-040 The bench SHALL cover: all three sources holding heads from reset -> grants in order 0, 1, 2, with one idle cycle between packets.
REQ-041 The bench SHALL cover: oready low for 5 cycles mid-packet -> sel held, no iready_n, and pkt_len unchanged by the stall.
REQ-042 The bench SHALL cover: a TYPE_HEADTAIL on port 2 -> busy for 1 cycle, then pkt_len = 1.
REQ-043 The bench SHALL cover: a HEAD flit injected mid-packet by the owner -> err = 1 and sticky, with the packet completing on its tail.
REQ-044 The bench SHALL cover: rst_ pulsed low mid-packet -> all outputs reset immediately, and the next grant goes to the lowest-index requester.
